icache_responder: RTL and testbench

Instruction-side cache that answers the fetch unit's instruction requests. Each cycle it checks whether the word at the fetch PC is cached. On a hit it returns the instruction and its length in the same cycle. On a miss it fetches four bytes through the memory arbiter's byte port, installs them, and serves the request afterwards. It sits between the fetch unit and the memory arbiter.

---
 rtl/icache_responder.sv | 109 ++++++++++
 tb/tb_icache_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache for the fetch unit: same-cycle hits, and
// byte-serial fills through the memory arbiter on a miss.
module icache_responder #(
  parameter int IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] fetch_pc,
  input  logic        ask_for,
  output logic        give_you,
  output logic [31:0] give_you_ins,
  output logic [2:0]  offset,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        mem_byte_valid,
  input  logic [7:0]  mem_byte,
  output logic        o_dbg_state,
  output logic [1:0]  o_dbg_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 31 - IDX_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Handshake: give_you is a level held while the PC hits (no accept signal);
  // the arbiter may present one byte per cycle while ic_req is high, and a
  // byte counts as taken only in a cycle where rdy_in is also high.
  state_t             r_state;
  logic [1:0]         r_cnt;
  logic [31:0]        r_buf;
  logic               r_ic_req;
  logic [31:0]        r_ic_addr;
  logic [DEPTH-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [DEPTH];
  logic [31:0]        r_data [DEPTH];

  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [31:0]        w_data;
  logic               w_hit;
  logic               w_take;
  logic               w_last;
  logic               w_unused;

  assign w_idx      = fetch_pc[IDX_W:1];
  assign w_fill_idx = r_ic_addr[IDX_W:1];
  assign w_data     = r_data[w_idx];
  assign w_hit      = rdy_in && ask_for && r_valid[w_idx] &&
                      (r_tag[w_idx] == fetch_pc[31:IDX_W+1]);
  assign w_take     = (r_state == S_FILL) && rdy_in && mem_byte_valid;
  assign w_last     = w_take && (r_cnt == 2'd3);
  assign w_unused   = fetch_pc[0] ^ r_ic_addr[0];

  assign give_you     = w_hit;
  assign give_you_ins = (w_data[1:0] == 2'b11) ? w_data : {16'b0, w_data[15:0]};
  assign offset       = (w_data[1:0] == 2'b11) ? 3'd4 : 3'd2;
  assign ic_req       = r_ic_req;
  assign ic_addr      = r_ic_addr;
  assign o_dbg_state  = r_state;
  assign o_dbg_cnt    = r_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_buf     <= 32'd0;
      r_ic_req  <= 1'b0;
      r_ic_addr <= 32'd0;
      r_valid   <= '0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (ask_for && !w_hit) begin
            r_state   <= S_FILL;
            r_ic_addr <= fetch_pc;
            r_cnt     <= 2'd0;
            r_ic_req  <= 1'b1;
          end
        end
        S_FILL: begin
          if (mem_byte_valid) begin
            r_buf[{r_cnt, 3'b000} +: 8] <= mem_byte;
            r_cnt                       <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_valid[w_fill_idx] <= 1'b1;
              r_ic_req            <= 1'b0;
              r_state             <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data need no reset: the valid bits alone gate every read.
  always_ff @(posedge clk_in) begin
    if (w_last && !rst_in) begin
      r_tag[w_fill_idx]  <= r_ic_addr[31:IDX_W+1];
      r_data[w_fill_idx] <= {mem_byte, r_buf[23:0]};
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: a table of miss/fill/hit vectors plus hand-written
// sequences for eviction, redirect, hit-under-miss, back-pressure, reset and rdy_in.
module tb_icache_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] fetch_pc;
  logic        ask_for;
  logic        give_you;
  logic [31:0] give_you_ins;
  logic [2:0]  offset;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        mem_byte_valid;
  logic [7:0]  mem_byte;
  logic        o_dbg_state;
  logic [1:0]  o_dbg_cnt;

  icache_responder #(.IDX_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_pc(fetch_pc), .ask_for(ask_for),
    .give_you(give_you), .give_you_ins(give_you_ins), .offset(offset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .mem_byte_valid(mem_byte_valid), .mem_byte(mem_byte),
    .o_dbg_state(o_dbg_state), .o_dbg_cnt(o_dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [34:0] exp_q[$];   // {offset, instruction}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares the current answer against the oldest expected one.
  task automatic check_give(input string name);
    logic [34:0] e;
    check({name, ".give_you"}, {31'b0, give_you}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got an answer, expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, ".ins"}, give_you_ins, e[31:0]);
      check({name, ".offset"}, {29'b0, offset}, {29'b0, e[34:32]});
    end
  endtask

  function automatic logic [31:0] model_ins(input logic [31:0] w);
    return (w[1:0] == 2'b11) ? w : {16'b0, w[15:0]};
  endfunction

  function automatic logic [2:0] model_off(input logic [31:0] w);
    return (w[1:0] == 2'b11) ? 3'd4 : 3'd2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Miss on pc, feed bytes (b0 = bytes[7:0]) on consecutive cycles, check answer.
  task automatic fill(input string name, input logic [31:0] pc, input logic [31:0] bytes,
                      input logic [31:0] ins, input logic [2:0] off);
    fetch_pc = pc;
    ask_for = 1'b1;
    mem_byte_valid = 1'b0;
    @(negedge clk_in);
    check({name, ".miss"}, {31'b0, give_you}, 32'd0);
    step();
    exp_q.push_back({off, ins});
    for (int i = 0; i < 4; i++) begin
      mem_byte_valid = 1'b1;
      mem_byte = bytes[i*8 +: 8];
      @(negedge clk_in);
      if (i == 0) begin
        check({name, ".ic_req"}, {31'b0, ic_req}, 32'd1);
        check({name, ".ic_addr"}, ic_addr, pc);
      end
      step();
    end
    mem_byte_valid = 1'b0;
    @(negedge clk_in);
    check({name, ".req_drop"}, {31'b0, ic_req}, 32'd0);
    check_give(name);
    step();
  endtask

  task automatic hit(input string name, input logic [31:0] pc,
                     input logic [31:0] ins, input logic [2:0] off);
    fetch_pc = pc;
    ask_for = 1'b1;
    exp_q.push_back({off, ins});
    @(negedge clk_in);
    check_give(name);
    check({name, ".no_req"}, {31'b0, ic_req}, 32'd0);
    step();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] bytes;
    logic [31:0] ins;
    logic [2:0]  off;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test ----------------
  initial begin
    logic [31:0] r;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    ask_for = 1'b1;
    fetch_pc = 32'h0;
    mem_byte_valid = 1'b0;
    mem_byte = 8'h0;

    vecs[0] = '{pc: 32'h0, bytes: 32'h0000_0513, ins: 32'h0000_0513, off: 3'd4};
    vecs[1] = '{pc: 32'h6, bytes: 32'h0513_4501, ins: 32'h0000_4501, off: 3'd2};
    vecs[2] = '{pc: 32'h8, bytes: 32'h0000_0513, ins: 32'h0000_0513, off: 3'd4};
    vecs[3] = '{pc: 32'h2, bytes: 32'h0010_0293, ins: 32'h0010_0293, off: 3'd4};
    for (int i = 4; i < 6; i++) begin
      r = $urandom();
      vecs[i].pc = {r[31:7], 6'(32 + i), 1'b0};
      vecs[i].bytes = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      vecs[i].ins = model_ins(vecs[i].bytes);
      vecs[i].off = model_off(vecs[i].bytes);
    end

    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset.give_you", {31'b0, give_you}, 32'd0);
    check("reset.ic_req", {31'b0, ic_req}, 32'd0);
    check("reset.ic_addr", ic_addr, 32'd0);
    check("reset.state", {31'b0, o_dbg_state}, 32'd0);
    step();
    rst_in = 1'b0;

    // Table: cold miss, fill, then same-cycle hit on re-ask.
    for (int i = 0; i < 6; i++) begin
      fill($sformatf("vec%0d.fill", i), vecs[i].pc, vecs[i].bytes, vecs[i].ins, vecs[i].off);
      hit($sformatf("vec%0d.rehit", i), vecs[i].pc, vecs[i].ins, vecs[i].off);
    end
    for (int i = 0; i < 6; i++)
      hit($sformatf("vec%0d.keep", i), vecs[i].pc, vecs[i].ins, vecs[i].off);

    ask_for = 1'b0;
    fetch_pc = 32'h0;
    @(negedge clk_in);
    check("no_ask.give_you", {31'b0, give_you}, 32'd0);
    step();

    // Conflict eviction: 0x80 shares index 0 with 0x0.
    fill("evict.fill80", 32'h80, 32'h0000_0113, 32'h0000_0113, 3'd4);
    fill("evict.refill0", 32'h0, 32'h0000_0513, 32'h0000_0513, 3'd4);

    // Redirect mid-fill: 0x10 must finish, then 0x40 starts its own fill.
    fetch_pc = 32'h10;
    ask_for = 1'b1;
    @(negedge clk_in);
    check("redir.miss10", {31'b0, give_you}, 32'd0);
    step();
    mem_byte_valid = 1'b1; mem_byte = 8'h93;
    @(negedge clk_in);
    check("redir.addr10", ic_addr, 32'h10);
    step();
    fetch_pc = 32'h40; mem_byte = 8'h00;
    @(negedge clk_in);
    check("redir.miss40_in_fill", {31'b0, give_you}, 32'd0);
    check("redir.addr_held", ic_addr, 32'h10);
    step();
    mem_byte = 8'ha0; step();
    mem_byte = 8'h00; step();
    mem_byte_valid = 1'b0;
    @(negedge clk_in);
    check("redir.req_drop", {31'b0, ic_req}, 32'd0);
    step();
    mem_byte_valid = 1'b1; mem_byte = 8'h13;
    @(negedge clk_in);
    check("redir.req40", {31'b0, ic_req}, 32'd1);
    check("redir.addr40", ic_addr, 32'h40);
    step();
    // Hit-under-miss on the cached pc 0x0.
    fetch_pc = 32'h0; mem_byte = 8'h01;
    exp_q.push_back({3'd4, 32'h0000_0513});
    @(negedge clk_in);
    check_give("hum.pc0");
    step();
    fetch_pc = 32'h40; mem_byte = 8'hb0; step();
    mem_byte = 8'h00; step();
    mem_byte_valid = 1'b0;
    // Back-pressure: answer held as a level for several cycles.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({3'd4, 32'h00b0_0113});
      @(negedge clk_in);
      check_give($sformatf("hold.c%0d", k));
      step();
    end
    hit("redir.installed10", 32'h10, 32'h00a0_0093, 3'd4);

    // Reset during a fill.
    fetch_pc = 32'h20;
    step();
    mem_byte_valid = 1'b1; mem_byte = 8'haa; step();
    mem_byte = 8'hbb; step();
    rst_in = 1'b1;
    #1;
    check("rst.req_async", {31'b0, ic_req}, 32'd0);
    check("rst.state", {31'b0, o_dbg_state}, 32'd0);
    mem_byte_valid = 1'b0;
    fetch_pc = 32'h0;
    step();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst.pc0_miss", {31'b0, give_you}, 32'd0);
    step();
    mem_byte_valid = 1'b1; mem_byte = 8'h13;
    @(negedge clk_in);
    check("rst.refill_req", {31'b0, ic_req}, 32'd1);
    check("rst.refill_addr", ic_addr, 32'h0);
    step();
    // rdy_in low: offered bytes (garbage) must not be taken.
    rdy_in = 1'b0; mem_byte = 8'hff;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      check($sformatf("rdy.cnt%0d", k), {30'b0, o_dbg_cnt}, 32'd1);
      check($sformatf("rdy.give%0d", k), {31'b0, give_you}, 32'd0);
      step();
    end
    rdy_in = 1'b1; mem_byte = 8'h05; step();
    mem_byte = 8'h00; step();
    mem_byte = 8'h00; step();
    mem_byte_valid = 1'b0;
    exp_q.push_back({3'd4, 32'h0000_0513});
    @(negedge clk_in);
    check_give("rdy.fill_done");
    step();
    rdy_in = 1'b0;
    @(negedge clk_in);
    check("rdy.hit_masked", {31'b0, give_you}, 32'd0);
    step();
    rdy_in = 1'b1;
    // Entries from before the reset are gone.
    fetch_pc = 32'h2;
    @(negedge clk_in);
    check("rst.pc2_gone", {31'b0, give_you}, 32'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard.drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
